// File: rtl/doodle_video_pkg.sv
// Shared palette and layer constants for the doodle video path.
package doodle_video_pkg;

  localparam int unsigned IDX_W = 4;

  localparam logic [3:0] PAL_BG_GRID = 4'h0;
  localparam logic [3:0] PAL_BLACK   = 4'h1;
  localparam logic [3:0] PAL_WHITE   = 4'h9;
  localparam logic [3:0] PAL_MAX     = 4'h9;

  typedef logic [1:0] layer_id_t;

  localparam layer_id_t LYR_DOODLER  = 2'd0;
  localparam layer_id_t LYR_MONSTER  = 2'd1;
  localparam layer_id_t LYR_PLATFORM = 2'd2;
  localparam layer_id_t LYR_SCORE    = 2'd3;

endpackage

// File: rtl/palette_prio_sel.sv
// Rank-ordered winner select over masked layer requests, with palette clamp.
module palette_prio_sel #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned IDX_W      = doodle_video_pkg::IDX_W,
  parameter int unsigned ID_W       = 2
) (
  input  logic [NUM_LAYERS-1:0]       i_req,
  input  logic [NUM_LAYERS*IDX_W-1:0] i_idx,
  input  logic [NUM_LAYERS*ID_W-1:0]  i_prio,
  output logic [IDX_W-1:0]            o_idx,
  output logic [NUM_LAYERS-1:0]       o_win
);
  import doodle_video_pkg::*;

  logic [ID_W-1:0]  w_id;
  logic [IDX_W-1:0] w_sel;
  logic             w_found;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_id    = '0;
    o_win   = '0;
    for (int r = 0; r < int'(NUM_LAYERS); r++) begin
      w_id = i_prio[r*ID_W +: ID_W];
      if (!w_found && i_req[w_id]) begin
        w_found     = 1'b1;
        o_win[w_id] = 1'b1;
        w_sel       = i_idx[int'(w_id)*IDX_W +: IDX_W];
      end
    end
    // Indices beyond the palette fold onto white
    if (!w_found) begin
      o_idx = IDX_W'(PAL_BG_GRID);
    end else if (w_sel > IDX_W'(PAL_MAX)) begin
      o_idx = IDX_W'(PAL_WHITE);
    end else begin
      o_idx = w_sel;
    end
  end

endmodule

// File: rtl/palette_layer_arbiter.sv
// Per-pixel layer arbiter: 2-stage pipeline with frame-synchronous config.
module palette_layer_arbiter #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned IDX_W      = doodle_video_pkg::IDX_W,
  parameter int unsigned BLINK_LOG2 = 3
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic                        pix_valid,
  input  logic                        frame_start,
  input  logic [NUM_LAYERS-1:0]       layer_req,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [NUM_LAYERS*2-1:0]     cfg_prio,
  input  logic [NUM_LAYERS-1:0]       cfg_en,
  input  logic [NUM_LAYERS-1:0]       cfg_blink,
  output logic                        cfg_err,
  output logic [IDX_W-1:0]            PaletteIndex,
  output logic [9:0]                  DrawX_o,
  output logic [9:0]                  DrawY_o,
  output logic                        pix_valid_o,
  output logic [NUM_LAYERS-1:0]       win_layer,
  output logic [7:0]                  frame_cnt
);
  import doodle_video_pkg::*;

  localparam int unsigned ID_W = 2;
  localparam int unsigned PW   = NUM_LAYERS * ID_W;

  typedef enum logic [0:0] {StEmpty, StPending} cfg_state_e;

  function automatic logic [PW-1:0] identity_prio();
    logic [PW-1:0] p;
    p = '0;
    for (int r = 0; r < int'(NUM_LAYERS); r++) p[r*ID_W +: ID_W] = ID_W'(r);
    return p;
  endfunction

  cfg_state_e                  r_state;
  logic [PW-1:0]               r_shd_prio, r_act_prio;
  logic [NUM_LAYERS-1:0]       r_shd_en, r_shd_blink, r_act_en, r_act_blink;
  logic                        r_cfg_ready, r_cfg_err;
  logic [7:0]                  r_frame_cnt;

  logic [9:0]                  r_s1_x, r_s1_y;
  logic                        r_s1_valid;
  logic [NUM_LAYERS-1:0]       r_s1_m;
  logic [NUM_LAYERS*IDX_W-1:0] r_s1_idx;
  logic [PW-1:0]               r_s1_prio;

  logic [IDX_W-1:0]            r_pal_idx;
  logic [9:0]                  r_x_o, r_y_o;
  logic                        r_valid_o;
  logic [NUM_LAYERS-1:0]       r_win;

  logic [NUM_LAYERS-1:0]       w_m;
  logic [NUM_LAYERS-1:0]       w_seen;
  logic                        w_perm_ok;
  logic [IDX_W-1:0]            w_sel_idx;
  logic [NUM_LAYERS-1:0]       w_sel_win;

  always_comb begin
    w_m = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      w_m[i] = layer_req[i] & r_act_en[i] & ~(r_act_blink[i] & r_frame_cnt[BLINK_LOG2]) &
               (layer_idx[i*IDX_W +: IDX_W] != '0);
    end
  end

  // Shadow is applied only if every layer id appears exactly once
  always_comb begin
    w_seen = '0;
    for (int r = 0; r < int'(NUM_LAYERS); r++) w_seen[r_shd_prio[r*ID_W +: ID_W]] = 1'b1;
    w_perm_ok = &w_seen;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= StEmpty;
      r_shd_prio  <= '0;
      r_shd_en    <= '0;
      r_shd_blink <= '0;
      r_act_prio  <= identity_prio();
      r_act_en    <= '1;
      r_act_blink <= '0;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        StEmpty: begin
          if (cfg_valid) begin
            r_shd_prio  <= cfg_prio;
            r_shd_en    <= cfg_en;
            r_shd_blink <= cfg_blink;
            r_cfg_ready <= 1'b0;
            r_state     <= StPending;
          end
        end
        StPending: begin
          if (frame_start) begin
            if (w_perm_ok) begin
              r_act_prio  <= r_shd_prio;
              r_act_en    <= r_shd_en;
              r_act_blink <= r_shd_blink;
            end else begin
              r_cfg_err <= 1'b1;
            end
            r_cfg_ready <= 1'b1;
            r_state     <= StEmpty;
          end
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_frame_cnt <= '0;
    end else if (frame_start) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_m     <= '0;
      r_s1_idx   <= '0;
      r_s1_prio  <= '0;
    end else begin
      r_s1_x     <= DrawX;
      r_s1_y     <= DrawY;
      r_s1_valid <= pix_valid;
      r_s1_m     <= w_m;
      r_s1_idx   <= layer_idx;
      r_s1_prio  <= r_act_prio;
    end
  end

  palette_prio_sel #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W),
    .ID_W       (ID_W)
  ) u_prio_sel (
    .i_req  (r_s1_m),
    .i_idx  (r_s1_idx),
    .i_prio (r_s1_prio),
    .o_idx  (w_sel_idx),
    .o_win  (w_sel_win)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pal_idx <= '0;
      r_x_o     <= '0;
      r_y_o     <= '0;
      r_valid_o <= 1'b0;
      r_win     <= '0;
    end else begin
      r_x_o     <= r_s1_x;
      r_y_o     <= r_s1_y;
      r_valid_o <= r_s1_valid;
      r_pal_idx <= r_s1_valid ? w_sel_idx : '0;
      r_win     <= r_s1_valid ? w_sel_win : '0;
    end
  end

  assign cfg_ready    = r_cfg_ready;
  assign cfg_err      = r_cfg_err;
  assign frame_cnt    = r_frame_cnt;
  assign PaletteIndex = r_pal_idx;
  assign DrawX_o      = r_x_o;
  assign DrawY_o      = r_y_o;
  assign pix_valid_o  = r_valid_o;
  assign win_layer    = r_win;

endmodule

// File: doc/palette_layer_arbiter.md
Name: palette_layer_arbiter

Overview:
- Per-pixel arbiter between sprite/layer generators (doodler, platforms, monsters, score) that all drive candidate palette indices.
- Picks one winner per pixel by a programmable priority order and drives PaletteIndex into the colour mapper.
- Delays DrawX/DrawY to match, so the colour mapper's grid pattern stays aligned.
- Owns frame-synchronous layer configuration (priority, enable, blink), applied only at frame boundaries to avoid tearing.

Parameters:
- NUM_LAYERS, 4, number of requesting layers; layer id 0..NUM_LAYERS-1.
- IDX_W, 4, palette index width.
- BLINK_LOG2, 3, blink half-period is 2^BLINK_LOG2 frames.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- pix_valid  in  1  DrawX/DrawY in active area this cycle.
- frame_start  in  1  one-cycle pulse at start of each frame.
- layer_req  in  NUM_LAYERS  layer i claims this pixel.
- layer_idx  in  NUM_LAYERS*IDX_W  layer i index, packed, layer 0 in LSBs.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  shadow config free.
- cfg_prio  in  NUM_LAYERS*2  rank r -> layer id, rank 0 = highest, packed rank 0 in LSBs.
- cfg_en  in  NUM_LAYERS  layer enables.
- cfg_blink  in  NUM_LAYERS  layer blinks when set.
- cfg_err  out  1  one-cycle pulse: applied config rejected.
- PaletteIndex  out  IDX_W  winning index to the colour mapper.
- DrawX_o  out  10  DrawX delayed 2 cycles.
- DrawY_o  out  10  DrawY delayed 2 cycles.
- pix_valid_o  out  1  pix_valid delayed 2 cycles.
- win_layer  out  NUM_LAYERS  one-hot winner, 0 if background (used for collision logic).
- frame_cnt  out  8  frames since reset.

Behaviour:
- Reset (async) values:
  - PaletteIndex=0, DrawX_o=0, DrawY_o=0, pix_valid_o=0, win_layer=0, cfg_err=0, cfg_ready=1, frame_cnt=0.
  - Active config: prio = identity (rank r -> layer r), en = all 1, blink = all 0.
  - Shadow empty.
- Pipeline, fixed latency 2, no stall:
  - Stage 1 registers DrawX/DrawY/pix_valid and the masked request vector m[i] = layer_req[i] & en[i] & ~(blink[i] & frame_cnt[BLINK_LOG2]) & (layer_idx[i] != 0), plus layer indices.
  - Stage 2 selects the lowest rank whose layer has m set.
  - Output index = that layer's index, clamped: values 10..15 are output as 9 (white).
  - No winner: output 0 (background grid), win_layer=0.
  - pix_valid_o=0 forces PaletteIndex=0 and win_layer=0.
- Config is sampled into stage 1 with the pixel. A pixel presented on the frame_start cycle uses the old config.
- Config FSM, states EMPTY and PENDING:
  - EMPTY: cfg_ready=1. cfg_valid -> capture cfg_* into shadow, go PENDING.
  - PENDING: cfg_ready=0. On frame_start -> validate shadow.
    - Valid = cfg_prio is a permutation of 0..NUM_LAYERS-1: active <= shadow.
    - Invalid: active unchanged, cfg_err pulses high the next cycle.
    - Either way go EMPTY.
  - cfg_valid and frame_start in the same cycle while EMPTY: accept into shadow; apply at the next frame_start, not this one.
  - At most one pending config; cfg_valid while cfg_ready=0 is ignored (not accepted).
- frame_cnt increments on every frame_start and wraps 255 -> 0. Blink phase = frame_cnt[BLINK_LOG2]; layer hidden while the phase bit is 1.
- Reset mid-frame: pipeline contents discarded, outputs return to reset values immediately.

Decomposition:
- Package doodle_video_pkg:
  - IDX_W.
  - PAL_BG_GRID=4'h0, PAL_BLACK=4'h1, PAL_WHITE=4'h9, PAL_MAX=4'h9.
  - typedef layer_id_t (2 bits).
  - Layer id constants: LYR_DOODLER=0, LYR_MONSTER=1, LYR_PLATFORM=2, LYR_SCORE=3.
- Sub-module palette_prio_sel (combinational): rank-ordered mux plus clamp. Inputs: masked requests, indices, prio. Outputs: index and one-hot winner.

Test Plan:
- Reset, layer 2 req idx 5, others idle, pix_valid=1 -> two cycles later PaletteIndex=5, win_layer=0100, DrawX_o/DrawY_o equal inputs from 2 cycles earlier.
- Layers 0 (idx 3) and 2 (idx 5) both req, identity prio -> 3. Offer cfg_prio ranks {2,0,1,3}: before frame_start still 3; after frame_start -> 5.
- Layer 1 req idx 12 -> PaletteIndex=9. Layer 1 req idx 0 with layer 3 idx 7 -> 7. No req -> 0, win_layer=0.
- cfg_blink[0]=1, layer 0 idx 1 held: visible frames 0-7, hidden frames 8-15 (output 0), visible again from frame 16.
- cfg_prio {0,0,1,2} offered -> cfg_ready=0 until frame_start. cfg_err pulses 1 cycle, old order retained, cfg_ready returns to 1.
- Assert Reset during active pixels with a config PENDING -> all outputs 0 immediately, cfg_ready=1, identity prio restored, frame_cnt=0.
